// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the cpu bus: word RAM plus a boot loader that fills it from a byte stream.
// Optional CPUMEM_WRITE_PROTECT_EN: cpu writes below load_count are dropped and flagged on wp_err.
module cpu_mem_responder #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          address,
  input  logic [31:0]          datai,
  input  logic                 rw,
  output logic [31:0]          data,
  output logic                 cpu_reset,
  input  logic                 load_valid,
  input  logic [7:0]           load_byte,
  input  logic                 load_last,
  output logic                 load_ready,
  output logic                 load_done,
  output logic [ADDR_BITS:0]   load_count,
  output logic                 addr_err,
`ifdef CPUMEM_WRITE_PROTECT_EN
  output logic                 wp_err,
`endif
  output logic [1:0]           dbg_state
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] LAST_IDX = (ADDR_BITS + 1)'(DEPTH - 1);

  // Loader handshake: a byte transfers on a posedge where load_valid and load_ready are both high.
  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_cpu_reset;
  logic                 r_load_ready;
  logic                 r_load_done;
  logic [ADDR_BITS:0]   r_load_count;
  logic [1:0]           r_idx;
  logic [23:0]          r_buf;
  logic                 r_addr_err;

  logic [31:0]          mem [DEPTH];

  logic                 w_accept;
  logic                 w_word_end;
  logic                 w_full;
  logic [31:0]          w_load_word;
  logic                 w_in_range;
  logic                 w_run;
  logic                 w_wp_block;
  logic                 w_cpu_we;
  logic                 w_we;
  logic [ADDR_BITS-1:0] w_waddr;
  logic [31:0]          w_wdata;

  assign w_accept    = (r_state == S_LOAD) && r_load_ready && load_valid;
  assign w_word_end  = w_accept && ((r_idx == 2'd3) || load_last);
  assign w_full      = (r_load_count == LAST_IDX);
  // Buffered bytes are zero above the current index, so a partial word comes out zero-padded.
  assign w_load_word = {8'h00, r_buf} | ({24'h000000, load_byte} << {r_idx, 3'b000});
  assign w_in_range  = ((address >> ADDR_BITS) == 32'd0);
  assign w_run       = (r_state == S_RUN);

`ifdef CPUMEM_WRITE_PROTECT_EN
  assign w_wp_block  = (address < {{(31 - ADDR_BITS){1'b0}}, r_load_count});
`else
  assign w_wp_block  = 1'b0;
`endif

  assign w_cpu_we = w_run && !rw && w_in_range && !w_wp_block;
  assign w_we     = w_word_end || w_cpu_we;
  assign w_waddr  = w_word_end ? r_load_count[ADDR_BITS-1:0] : address[ADDR_BITS-1:0];
  assign w_wdata  = w_word_end ? w_load_word : datai;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT: w_next = S_LOAD;
      S_LOAD: if (w_word_end && (load_last || w_full)) w_next = S_RUN;
      S_RUN:  w_next = S_RUN;
      default: w_next = S_INIT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_INIT;
      r_cpu_reset  <= 1'b1;
      r_load_ready <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_count <= '0;
      r_idx        <= 2'd0;
      r_buf        <= 24'h000000;
      r_addr_err   <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_load_ready <= (w_next == S_LOAD);
      r_load_done  <= (w_next == S_RUN);
      r_cpu_reset  <= (w_next != S_RUN);
      if (w_accept) begin
        if (w_word_end) begin
          r_load_count <= r_load_count + (ADDR_BITS + 1)'(1);
          r_idx        <= 2'd0;
          r_buf        <= 24'h000000;
        end else begin
          r_idx <= r_idx + 2'd1;
          case (r_idx)
            2'd0:    r_buf[7:0]   <= load_byte;
            2'd1:    r_buf[15:8]  <= load_byte;
            2'd2:    r_buf[23:16] <= load_byte;
            default: r_buf        <= r_buf;
          endcase
        end
      end
      if (w_run && !w_in_range) r_addr_err <= 1'b1;
    end
  end

`ifdef CPUMEM_WRITE_PROTECT_EN
  logic r_wp_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wp_err <= 1'b0;
    end else if (w_run && !rw && w_in_range && w_wp_block) begin
      r_wp_err <= 1'b1;
    end
  end

  assign wp_err = r_wp_err;
`endif

  // RAM contents survive reset so a reload only overwrites what it streams in.
  always_ff @(posedge clock) begin
    if (w_we) mem[w_waddr] <= w_wdata;
  end

  assign data       = (r_cpu_reset || !w_in_range) ? 32'd0 : mem[address[ADDR_BITS-1:0]];
  assign cpu_reset  = r_cpu_reset;
  assign load_ready = r_load_ready;
  assign load_done  = r_load_done;
  assign load_count = r_load_count;
  assign addr_err   = r_addr_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: a 1024-word instance and a 4-word instance for the full-RAM case.
module tb_cpu_mem_responder;

  logic        clk;
  logic        rst;

  logic [31:0] a_address, a_datai, a_data;
  logic        a_rw, a_cpu_reset, a_valid, a_last, a_ready, a_done, a_addr_err;
  logic [7:0]  a_byte;
  logic [10:0] a_count;
  logic [1:0]  a_state;

  logic [31:0] b_address, b_datai, b_data;
  logic        b_rw, b_cpu_reset, b_valid, b_last, b_ready, b_done, b_addr_err;
  logic [7:0]  b_byte;
  logic [2:0]  b_count;
  logic [1:0]  b_state;

`ifdef CPUMEM_WRITE_PROTECT_EN
  logic        a_wp_err, b_wp_err;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  cpu_mem_responder #(.ADDR_BITS(10)) u_dut_a (
    .clock(clk), .reset(rst), .address(a_address), .datai(a_datai), .rw(a_rw),
    .data(a_data), .cpu_reset(a_cpu_reset), .load_valid(a_valid), .load_byte(a_byte),
    .load_last(a_last), .load_ready(a_ready), .load_done(a_done), .load_count(a_count),
    .addr_err(a_addr_err),
`ifdef CPUMEM_WRITE_PROTECT_EN
    .wp_err(a_wp_err),
`endif
    .dbg_state(a_state)
  );

  cpu_mem_responder #(.ADDR_BITS(2)) u_dut_b (
    .clock(clk), .reset(rst), .address(b_address), .datai(b_datai), .rw(b_rw),
    .data(b_data), .cpu_reset(b_cpu_reset), .load_valid(b_valid), .load_byte(b_byte),
    .load_last(b_last), .load_ready(b_ready), .load_done(b_done), .load_count(b_count),
    .addr_err(b_addr_err),
`ifdef CPUMEM_WRITE_PROTECT_EN
    .wp_err(b_wp_err),
`endif
    .dbg_state(b_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // driver tasks
  task automatic a_send(input logic [7:0] b, input logic last);
    @(negedge clk);
    a_valid = 1'b1;
    a_byte  = b;
    a_last  = last;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    a_last  = 1'b0;
  endtask

  task automatic b_send(input logic [7:0] b, input logic last);
    @(negedge clk);
    b_valid = 1'b1;
    b_byte  = b;
    b_last  = last;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    b_last  = 1'b0;
  endtask

  task automatic a_read(input logic [31:0] addr);
    @(negedge clk);
    a_rw      = 1'b1;
    a_address = addr;
    #1;
  endtask

  task automatic a_write(input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    a_rw      = 1'b0;
    a_address = addr;
    a_datai   = wd;
    @(posedge clk);
    #1;
    a_rw = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    a_address = 32'd0; a_datai = 32'd0; a_rw = 1'b1;
    a_valid = 1'b0; a_byte = 8'h00; a_last = 1'b0;
    b_address = 32'd0; b_datai = 32'd0; b_rw = 1'b1;
    b_valid = 1'b0; b_byte = 8'h00; b_last = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_reset", a_cpu_reset, 1);
    check("rst_load_ready", a_ready, 0);
    check("rst_load_done", a_done, 0);
    check("rst_load_count", a_count, 0);
    check("rst_addr_err", a_addr_err, 0);
    check("rst_data", a_data, 0);
    check("rst_state", a_state, 0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    check("init_not_ready", a_ready, 0);
    @(posedge clk);
    #1;
    check("load_ready_after_init", a_ready, 1);
    check("state_load", a_state, 1);

    // first word with a long stall mid-word
    a_send(8'h11, 1'b0);
    a_send(8'h22, 1'b0);
    a_send(8'h33, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("stall_ready", a_ready, 1);
    check("stall_cpu_reset", a_cpu_reset, 1);
    check("stall_count", a_count, 0);
    a_send(8'h44, 1'b0);
    check("word0_count", a_count, 1);
    check("word0_cpu_reset", a_cpu_reset, 1);
    a_send(8'h55, 1'b1);
    check("last_cpu_reset", a_cpu_reset, 0);
    check("last_load_done", a_done, 1);
    check("last_load_ready", a_ready, 0);
    check("last_count", a_count, 2);
    check("state_run", a_state, 2);

    a_read(32'd0);
    check("mem0", a_data, 32'h44332211);
    a_read(32'd1);
    check("mem1_partial", a_data, 32'h00000055);

    // cpu write then combinational read-back
    a_write(32'd3, 32'hDEADBEEF);
    a_address = 32'd3;
    #1;
    check("wr_rd_mem3", a_data, 32'hDEADBEEF);
    check("no_addr_err", a_addr_err, 0);

    // out-of-range access
    a_read(32'h400);
    check("oor_data", a_data, 0);
    @(posedge clk);
    #1;
    check("oor_addr_err", a_addr_err, 1);
    a_write(32'h403, 32'h12345678);
    a_read(32'd3);
    check("oor_write_no_effect", a_data, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    check("addr_err_sticky", a_addr_err, 1);

    // async reset from run
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_cpu_reset", a_cpu_reset, 1);
    check("async_addr_err_clr", a_addr_err, 0);
    check("async_load_done_clr", a_done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // reset in the middle of the second word
    a_send(8'hA1, 1'b0);
    a_send(8'hA2, 1'b0);
    a_send(8'hA3, 1'b0);
    a_send(8'hA4, 1'b0);
    a_send(8'hB1, 1'b0);
    a_send(8'hB2, 1'b0);
    check("midload_count", a_count, 1);
    #2;
    rst = 1'b1;
    #1;
    check("midload_rst_count", a_count, 0);
    check("midload_rst_ready", a_ready, 0);
    check("midload_rst_cpu_reset", a_cpu_reset, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    a_send(8'h99, 1'b1);
    check("reload_count", a_count, 1);
    check("reload_cpu_reset", a_cpu_reset, 0);
    a_read(32'd0);
    check("reload_mem0", a_data, 32'h00000099);
    a_read(32'd1);
    check("reload_mem1_kept", a_data, 32'h00000055);
    a_read(32'd3);
    check("reload_mem3_kept", a_data, 32'hDEADBEEF);

`ifdef CPUMEM_WRITE_PROTECT_EN
    check("wp_err_clear", a_wp_err, 0);
    a_write(32'd0, 32'hCAFEF00D);
    check("wp_err_set", a_wp_err, 1);
    a_read(32'd0);
    check("wp_mem0_unchanged", a_data, 32'h00000099);
    a_write(32'd2, 32'h0BADF00D);
    a_read(32'd2);
    check("wp_mem2_written", a_data, 32'h0BADF00D);
`endif

    // 4-word instance: fill without load_last
    for (int i = 0; i < 16; i++) begin
      b_send(8'(i + 1), 1'b0);
      if (i == 14) begin
        check("b_count_before_full", b_count, 3);
        check("b_ready_before_full", b_ready, 1);
      end
    end
    check("b_full_count", b_count, 4);
    check("b_full_cpu_reset", b_cpu_reset, 0);
    check("b_full_ready", b_ready, 0);
    check("b_full_done", b_done, 1);
    b_send(8'hEE, 1'b0);
    check("b_17th_count", b_count, 4);
    check("b_17th_ready", b_ready, 0);
    @(negedge clk);
    b_address = 32'd3;
    #1;
    check("b_mem3", b_data, 32'h100F0E0D);
    b_address = 32'd0;
    #1;
    check("b_mem0", b_data, 32'h04030201);
    b_address = 32'd4;
    #1;
    check("b_oor_data", b_data, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the cpu bus: serves the cpu's `address`/`datao`/`rw` requests and returns read data on `data`.
- Contains a word-addressed RAM of 2^ADDR_BITS x 32.
- Contains a boot-loader FSM that fills the RAM from a byte stream while holding the cpu in reset, then releases it.
- Sits between the cpu and the board-level host/loader interface.

Parameters:
- ADDR_BITS, 10, RAM depth is 2^ADDR_BITS words (DEPTH).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- address  in  32  word address from cpu.
- datai  in  32  write data from cpu (cpu `datao`).
- rw  in  1  1 = read, 0 = write.
- data  out  32  read data to cpu.
- cpu_reset  out  1  drives the cpu `reset`; high until loading completes.
- load_valid  in  1  loader byte valid.
- load_byte  in  8  loader byte.
- load_last  in  1  qualifies the final byte of the image.
- load_ready  out  1  responder can accept a byte this cycle.
- load_done  out  1  image loaded; cpu running.
- load_count  out  ADDR_BITS+1  number of words written by the loader.
- addr_err  out  1  sticky: cpu accessed an address >= DEPTH.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports `clock`, `reset`).
- Reset values: state=S_INIT, cpu_reset=1, load_ready=0, load_done=0, load_count=0, byte index=0, assembly buffer=0, addr_err=0, data=0. RAM contents are not reset.
- FSM states and transitions:
  - S_INIT: exactly 1 cycle after reset deasserts, then S_LOAD.
  - S_LOAD: load_ready=1. A byte is accepted on a posedge with load_valid & load_ready.
  - S_RUN: load_ready=0, load_done=1, cpu_reset=0. All three are registered, updating on the edge that enters S_RUN.
- Byte assembly (little-endian):
  - Accepted byte number k (0..3) goes to bits [8k+7:8k].
  - On the edge accepting byte k=3, write the full word (3 buffered bytes + current byte) to mem[load_count], increment load_count, clear the index and buffer.
  - If load_last is set on an accepted byte with k<3, write the partial word zero-padded in the upper bytes on the same edge, increment load_count, go to S_RUN.
  - If load_last is set on k=3, write normally, then go to S_RUN.
- Full: the edge writing word index DEPTH-1 moves to S_RUN regardless of load_last (load_count=DEPTH). No further bytes are accepted.
- Load_valid low: no state change; the byte index is held indefinitely.
- Cpu read path (combinational, so the cpu can capture on the negedge in the same cycle):
  - cpu_reset=1: data=0.
  - cpu_reset=0, address < DEPTH: data = mem[address[ADDR_BITS-1:0]].
  - cpu_reset=0, address >= DEPTH: data = 0.
  - data does not depend on rw.
- Cpu write: in S_RUN with rw=0 and address < DEPTH, mem[address] <= datai on posedge. Writes while cpu_reset=1 are ignored.
- addr_err: set on a posedge in S_RUN when address >= DEPTH (read or write). Only reset clears it.
- Out-of-range writes have no effect on the RAM.
- Reset mid-load: the partial word is discarded, load_count=0, FSM returns to S_INIT, cpu_reset reasserts immediately (async). RAM keeps the words already written.
- Simultaneous events: loader and cpu never write in the same cycle, because cpu writes are gated by S_RUN.

Optional Feature:
- Macro: CPUMEM_WRITE_PROTECT_EN.
- Defined:
  - Cpu writes to address < load_count are suppressed; the RAM is unchanged.
  - Extra output wp_err (1 bit, reset 0) is set sticky on any suppressed write.
  - Reads are unaffected.
- Undefined: no wp_err port; all in-range cpu writes in S_RUN succeed.

Test Plan:
- Reset, then stream bytes 0x11,0x22,0x33,0x44,0x55 (last on 0x55) -> mem[0]=0x44332211, mem[1]=0x00000055, load_count=2, cpu_reset falls on the edge after 0x55, load_done=1.
- Hold load_valid low 20 cycles mid-word, then resume -> word assembled correctly; load_ready stays 1; cpu_reset stays 1.
- ADDR_BITS=2, stream 16 bytes with no load_last -> load_count=4, S_RUN entered, 17th byte not accepted (load_ready=0).
- In S_RUN: rw=0, address=3, datai=0xDEADBEEF; then rw=1, address=3 -> data=0xDEADBEEF before the next negedge.
- In S_RUN: address=0x400 (ADDR_BITS=10) -> data=0, addr_err=1, RAM unchanged, addr_err stays 1 after a valid access.
- Assert reset after 2 bytes of the second word -> cpu_reset=1 immediately, load_count=0, restarted load writes from mem[0]. With CPUMEM_WRITE_PROTECT_EN: a cpu write to address 0 after loading 2 words leaves mem[0] unchanged and sets wp_err=1.
